// File: rtl/mp_pkg.sv
// Shared types and defaults for the multiprocessor shared-memory responder.
package mp_pkg;

  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int NUM_CORES      = 4;
  localparam int CORE_W         = $clog2(NUM_CORES);

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_READ   = 4'd1,
    OP_WRITE  = 4'd2,
    OP_LOCK   = 4'd3,
    OP_UNLOCK = 4'd4
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_RESP
  } state_t;

  // True for any opcode with a defined meaning; everything above OP_UNLOCK is illegal.
  function automatic logic is_known_op(input logic [3:0] op);
    return op <= 4'(OP_UNLOCK);
  endfunction

endpackage

// File: rtl/mp_mem_array.sv
// Single-port synchronous RAM: write-enable, registered read, contents never reset.
module mp_mem_array #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write on enable and register the read word every cycle.
  // NOTE: no reset on the array so it maps onto block RAM; power-up contents are undefined.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mp_mem_responder.sv
// Shared-memory request responder: req/gnt handshake, internal RAM, per-core exclusive lock.
module mp_mem_responder
  import mp_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic [CORE_W-1:0]     core_id,
  input  logic [3:0]            opcode,
  input  logic                  read_en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  gnt,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rvalid,
  output logic                  err,
  output logic                  locked,
  output logic [CORE_W-1:0]     lock_owner
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_we;

  logic op_read, op_write, op_lock, op_unlock;
  logic rd_ok, wr_ok, unlock_ok, illegal;

  // Decode the request on the bus; only meaningful when gnt is high.
  always_comb begin
    op_read   = (opcode == OP_READ);
    op_write  = (opcode == OP_WRITE);
    op_lock   = (opcode == OP_LOCK);
    op_unlock = (opcode == OP_UNLOCK);
    rd_ok     = op_read  && read_en && !we;
    wr_ok     = op_write && we && !read_en;
    // A granted request always comes from the owner or while unlocked, so only the
    // locked flag decides whether an unlock does anything.
    unlock_ok = op_unlock && locked;
    illegal   = !is_known_op(opcode)
              || (op_read  && !rd_ok)
              || (op_write && !wr_ok)
              || (op_unlock && !locked);
  end

  // Next-state and grant: only IDLE accepts, and a foreign core stalls while locked.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_nxt = state;
    gnt       = 1'b0;
    case (state)
      IDLE: begin
        gnt = req && !(locked && (core_id != lock_owner));
        if (gnt && rd_ok) state_nxt = RD_WAIT;
      end
      RD_WAIT: state_nxt = RD_RESP;
      RD_RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Read address capture, lock bookkeeping and registered response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr    <= '0;
      locked     <= 1'b0;
      lock_owner <= '0;
      err        <= 1'b0;
      rvalid     <= 1'b0;
      data_out   <= '0;
    end else begin
      rvalid <= (state == RD_RESP);
      err    <= gnt && illegal;
      if (state == RD_RESP) data_out <= ram_rdata;
      if (gnt && rd_ok)     rd_addr  <= addr;
      if (gnt && op_lock) begin
        locked     <= 1'b1;
        lock_owner <= core_id;
      end
      if (gnt && unlock_ok) begin
        locked     <= 1'b0;
        lock_owner <= '0;
      end
    end
  end

  // The single RAM port serves writes from the bus in IDLE and the captured read in RD_WAIT.
  assign ram_addr = (state == IDLE) ? addr : rd_addr;
  assign ram_we   = gnt && wr_ok;

  mp_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(data_in),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mp_mem_responder.sv
// Directed self-checking bench for mp_mem_responder.
module tb_mp_mem_responder;
  import mp_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic [1:0]  core_id;
  logic [3:0]  opcode;
  logic        read_en;
  logic        we;
  logic [10:0] addr;
  logic [7:0]  data_in;
  logic        gnt;
  logic [7:0]  data_out;
  logic        rvalid;
  logic        err;
  logic        locked;
  logic [1:0]  lock_owner;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mp_mem_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .core_id   (core_id),
    .opcode    (opcode),
    .read_en   (read_en),
    .we        (we),
    .addr      (addr),
    .data_in   (data_in),
    .gnt       (gnt),
    .data_out  (data_out),
    .rvalid    (rvalid),
    .err       (err),
    .locked    (locked),
    .lock_owner(lock_owner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic exp_rvalid, input logic exp_err,
                            input logic exp_locked, input logic [1:0] exp_owner);
    check({tag, ".rvalid"}, 32'(rvalid), 32'(exp_rvalid));
    check({tag, ".err"}, 32'(err), 32'(exp_err));
    check({tag, ".locked"}, 32'(locked), 32'(exp_locked));
    check({tag, ".owner"}, 32'(lock_owner), 32'(exp_owner));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [3:0] op, input logic re,
                       input logic w, input logic [10:0] a, input logic [7:0] d);
    req = 1'b1; core_id = c; opcode = op; read_en = re; we = w; addr = a; data_in = d;
    #1;
  endtask

  task automatic idle();
    req = 1'b0; opcode = 4'h0; read_en = 1'b0; we = 1'b0;
    #1;
  endtask

  // Full read transaction with a hand-computed expected word.
  task automatic do_read(input string tag, input logic [1:0] c, input logic [10:0] a,
                         input logic [7:0] exp);
    drive(c, OP_READ, 1'b1, 1'b0, a, 8'h00);
    check({tag, ".gnt"}, 32'(gnt), 32'd1);
    tick();  // accept edge A
    idle();
    check({tag, ".rv_a"}, 32'(rvalid), 32'd0);
    tick();  // A+1
    check({tag, ".rv_a1"}, 32'(rvalid), 32'd0);
    tick();  // A+2
    check({tag, ".rv_a2"}, 32'(rvalid), 32'd1);
    check({tag, ".data"}, 32'(data_out), 32'(exp));
    tick();
    check({tag, ".rv_end"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    req = 1'b0; core_id = 2'd0; opcode = 4'h0; read_en = 1'b0; we = 1'b0;
    addr = '0; data_in = '0;
    tick(); tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 2'd0);
    check("reset.data", 32'(data_out), 32'h0);
    reset_n = 1'b1;
    tick();

    // Reset arriving mid-read drops the response.
    drive(2'd0, OP_READ, 1'b1, 1'b0, 11'h005, 8'h00);
    check("midrd.gnt", 32'(gnt), 32'd1);
    tick();  // A
    idle();
    tick();  // A+1
    reset_n = 1'b0;
    #1;
    check_outs("midrd.in_rst", 1'b0, 1'b0, 1'b0, 2'd0);
    check("midrd.data", 32'(data_out), 32'h0);
    check("midrd.gnt_rst", 32'(gnt), 32'd0);
    tick();
    check("midrd.rv_rst", 32'(rvalid), 32'd0);
    reset_n = 1'b1;
    tick();
    check("midrd.rv_post1", 32'(rvalid), 32'd0);
    tick();
    check("midrd.rv_post2", 32'(rvalid), 32'd0);
    drive(2'd0, OP_NOP, 1'b0, 1'b0, 11'h000, 8'h00);
    check("midrd.gnt_after", 32'(gnt), 32'd1);
    tick();
    idle();
    check_outs("midrd.nop", 1'b0, 1'b0, 1'b0, 2'd0);

    // Write then read at the top address; gnt stays low during the read wait.
    drive(2'd1, OP_WRITE, 1'b0, 1'b1, 11'h7FF, 8'hA5);
    check("wr.gnt", 32'(gnt), 32'd1);
    tick();
    drive(2'd1, OP_READ, 1'b1, 1'b0, 11'h7FF, 8'h00);
    check("rd7ff.gnt", 32'(gnt), 32'd1);
    tick();  // A
    drive(2'd1, OP_NOP, 1'b0, 1'b0, 11'h000, 8'h00);
    check("rd7ff.gnt_a", 32'(gnt), 32'd0);
    check("rd7ff.rv_a", 32'(rvalid), 32'd0);
    tick();  // A+1
    check("rd7ff.gnt_a1", 32'(gnt), 32'd0);
    check("rd7ff.rv_a1", 32'(rvalid), 32'd0);
    tick();  // A+2
    check("rd7ff.rv_a2", 32'(rvalid), 32'd1);
    check("rd7ff.data", 32'(data_out), 32'hA5);
    check("rd7ff.err", 32'(err), 32'd0);
    check("rd7ff.gnt_a2", 32'(gnt), 32'd1);
    tick();  // A+3 accepts the held NOP
    idle();
    check("rd7ff.rv_a3", 32'(rvalid), 32'd0);
    check("rd7ff.hold", 32'(data_out), 32'hA5);

    // Back-to-back writes, one per cycle.
    for (int i = 0; i < 4; i++) begin
      drive(2'd1, OP_WRITE, 1'b0, 1'b1, 11'(i), 8'(8'h10 + i));
      check($sformatf("b2b.gnt%0d", i), 32'(gnt), 32'd1);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++)
      do_read($sformatf("b2b.rd%0d", i), 2'd1, 11'(i), 8'(8'h10 + i));

    // Lock exclusion: core 3 stalls while core 2 holds the lock.
    drive(2'd2, OP_LOCK, 1'b0, 1'b0, 11'h000, 8'h00);
    check("lk.gnt", 32'(gnt), 32'd1);
    tick();
    idle();
    check_outs("lk.set", 1'b0, 1'b0, 1'b1, 2'd2);
    drive(2'd3, OP_WRITE, 1'b0, 1'b1, 11'h100, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lk.stall%0d", i), 32'(gnt), 32'd0);
      tick();
    end
    check_outs("lk.stalled", 1'b0, 1'b0, 1'b1, 2'd2);
    drive(2'd2, OP_UNLOCK, 1'b0, 1'b0, 11'h000, 8'h00);
    check("lk.unl_gnt", 32'(gnt), 32'd1);
    tick();
    check_outs("lk.unl", 1'b0, 1'b0, 1'b0, 2'd0);
    drive(2'd3, OP_WRITE, 1'b0, 1'b1, 11'h100, 8'h3C);
    check("lk.c3_gnt", 32'(gnt), 32'd1);
    tick();
    idle();
    do_read("lk.rd100", 2'd3, 11'h100, 8'h3C);

    // Illegal operations: accepted, err for one cycle, no side effects.
    drive(2'd0, 4'hF, 1'b0, 1'b1, 11'h000, 8'hEE);
    check("ill_f.gnt", 32'(gnt), 32'd1);
    tick();
    idle();
    check_outs("ill_f.acc", 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    check_outs("ill_f.after", 1'b0, 1'b0, 1'b0, 2'd0);
    do_read("ill_f.mem", 2'd0, 11'h000, 8'h10);

    drive(2'd0, OP_READ, 1'b1, 1'b1, 11'h001, 8'h00);
    check("ill_rdwe.gnt", 32'(gnt), 32'd1);
    tick();
    idle();
    check_outs("ill_rdwe.acc", 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    check_outs("ill_rdwe.a1", 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    check_outs("ill_rdwe.a2", 1'b0, 1'b0, 1'b0, 2'd0);

    drive(2'd0, OP_WRITE, 1'b1, 1'b1, 11'h002, 8'h77);
    tick();
    idle();
    check_outs("ill_wrre.acc", 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    do_read("ill_wrre.mem", 2'd0, 11'h002, 8'h12);

    drive(2'd1, OP_UNLOCK, 1'b0, 1'b0, 11'h000, 8'h00);
    check("ill_unl.gnt", 32'(gnt), 32'd1);
    tick();
    idle();
    check_outs("ill_unl.acc", 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    check_outs("ill_unl.after", 1'b0, 1'b0, 1'b0, 2'd0);

    // Re-lock by owner is silent; a foreign unlock is never granted.
    drive(2'd0, OP_LOCK, 1'b0, 1'b0, 11'h000, 8'h00);
    tick();
    check_outs("relk.first", 1'b0, 1'b0, 1'b1, 2'd0);
    check("relk.gnt2", 32'(gnt), 32'd1);
    tick();
    idle();
    check_outs("relk.second", 1'b0, 1'b0, 1'b1, 2'd0);
    drive(2'd1, OP_UNLOCK, 1'b0, 1'b0, 11'h000, 8'h00);
    check("relk.foreign0", 32'(gnt), 32'd0);
    tick();
    check("relk.foreign1", 32'(gnt), 32'd0);
    tick();
    check_outs("relk.held", 1'b0, 1'b0, 1'b1, 2'd0);
    drive(2'd0, OP_UNLOCK, 1'b0, 1'b0, 11'h000, 8'h00);
    check("relk.own_gnt", 32'(gnt), 32'd1);
    tick();
    idle();
    check_outs("relk.unl", 1'b0, 1'b0, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mp_mem_responder.md
Name: mp_mem_responder

Overview:
- DUT-side responder for the multiprocessor shared-memory request channel.
- Accepts tagged requests (core_id, opcode, addr, data) on a req/gnt handshake and executes them against an internal 2^ADDR_WIDTH x DATA_WIDTH memory.
- Returns read data with rvalid and supports an exclusive per-core lock.
- Sits between the core-side request bus and memory; the class-based bench drives its inputs.

Parameters:
- ADDR_WIDTH, 11, address width; memory depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 8, data word width.

Ports:
- clk  input  1  single clock, all state on posedge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  1  request valid from a core.
- core_id  input  2  requesting core tag.
- opcode  input  4  operation code (mp_pkg::opcode_t).
- read_en  input  1  read qualifier.
- we  input  1  write qualifier.
- addr  input  ADDR_WIDTH  word address.
- data_in  input  DATA_WIDTH  write data.
- gnt  output  1  request accepted this cycle (combinational).
- data_out  output  DATA_WIDTH  read data, registered.
- rvalid  output  1  one-cycle pulse, data_out valid.
- err  output  1  one-cycle pulse, last accepted request was illegal.
- locked  output  1  lock held.
- lock_owner  output  2  core holding lock, 0 when unlocked.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rvalid=0, err=0, data_out=0, locked=0, lock_owner=0. Memory contents not reset. An in-flight read is dropped and no rvalid is produced.
- gnt = (state==IDLE) && req && !(locked && core_id!=lock_owner).
- Accept: a request is accepted at the posedge where gnt=1. Inputs are sampled at that edge only.
- State machine:
  - IDLE: reads go to RD_WAIT; all other opcodes stay in IDLE.
  - RD_WAIT goes to RD_RESP; RD_RESP goes to IDLE.
  - gnt=0 in RD_WAIT and RD_RESP.
- OP_NOP (0): accepted, no effect.
- OP_READ (1):
  - Legal iff read_en=1 and we=0.
  - Memory is read at edge A+1, where A is the accept edge. data_out and rvalid=1 are registered at edge A+2, so rvalid is high for exactly the cycle after edge A+2.
  - Next request can be accepted at edge A+3.
  - data_out holds its value until the next read response.
- OP_WRITE (2):
  - Legal iff we=1 and read_en=0.
  - mem[addr]<=data_in at the accept edge. Stays in IDLE, so back-to-back writes run one per cycle.
  - A read accepted on the next edge returns the new data.
- OP_LOCK (3):
  - If unlocked, or lock_owner==core_id: locked<=1, lock_owner<=core_id.
  - Re-lock by the owner is legal and a no-op.
- OP_UNLOCK (4):
  - If locked and owner==core_id: locked<=0, lock_owner<=0.
  - Unlock while unlocked: err.
- Opcodes 5..15, or a qualifier mismatch on READ/WRITE (including read_en=we=1): accepted, no memory or lock effect, err=1 for one cycle after the accept edge.
- Locked by another core: that core's req sees gnt=0 and stalls (not an error). The requester must hold req and its fields stable until gnt.
- No arbitration between cores inside this block: one request bus. core_id only tags the request and is checked against the lock.
- err and rvalid never assert in the same cycle for the same request.

Decomposition:
- mp_pkg:
  - typedef enum logic[3:0] opcode_t {OP_NOP=0, OP_READ=1, OP_WRITE=2, OP_LOCK=3, OP_UNLOCK=4}.
  - typedef enum state_t {IDLE, RD_WAIT, RD_RESP}.
  - localparams ADDR_WIDTH_DEF=11, DATA_WIDTH_DEF=8, NUM_CORES=4.
- Sub-module mp_mem_array: single-port synchronous RAM (write-enable, registered read, no reset), instantiated once.

Test Plan:
- Reset mid-read: core 0 READ accepted, reset_n=0 one cycle later -> rvalid never asserts; all outputs 0 during reset; gnt=1 to the next req after release.
- Write then read: core 1 WRITE addr=0x7FF data=0xA5, then READ addr=0x7FF (read_en=1) -> gnt low 2 cycles; rvalid=1 exactly 2 edges after accept with data_out=0xA5.
- Back-to-back writes: addr 0..3 with data 0x10..0x13 on 4 consecutive cycles -> gnt held high each cycle; subsequent reads return 0x10..0x13.
- Lock exclusion: core 2 LOCK -> locked=1, lock_owner=2. Core 3 WRITE req -> gnt=0 indefinitely; core 2 UNLOCK -> core 3 granted next cycle and the write lands.
- Illegal ops: opcode=4'hF; READ with we=1; UNLOCK while unlocked -> each accepted with err pulsing one cycle; memory and lock unchanged; no rvalid.
- Re-lock and foreign unlock: core 0 LOCK twice -> no err; core 1 cannot issue UNLOCK (gnt=0); core 0 UNLOCK -> locked=0, lock_owner=0.
